// File: rtl/neural_layer_scheduler.sv
// Layer of NEURONS two-input threshold neurons evaluated one after another on a
// single shared signed multiplier: acc = bias<<<F + A*coeffA + B*coeffB, out = acc>0 ? 1.0 : 0.
module neural_layer_scheduler #(
    parameter int WIDTH   = 16,
    parameter int NEURONS = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       cfg_we,
    input  logic [3:0]                 cfg_addr,
    input  logic [WIDTH-1:0]           cfg_data,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           inputA,
    input  logic [WIDTH-1:0]           inputB,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [NEURONS*WIDTH-1:0]   out_data,
    output logic                       busy
);

    localparam int FRAC = WIDTH / 2;
    localparam int PW   = 2 * WIDTH;
    localparam int AW   = 2 * WIDTH + 2;
    localparam int IDXW = (NEURONS > 1) ? $clog2(NEURONS) : 1;

    localparam logic [WIDTH-1:0] ONE_Q    = WIDTH'(1) << FRAC;
    localparam logic [IDXW-1:0]  LAST_IDX = IDXW'(NEURONS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MAC_A,
        MAC_B,
        ACT,
        DONE
    } state_t;

    state_t                      state_q, state_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic signed [WIDTH-1:0]     in_a_q, in_a_d;
    logic signed [WIDTH-1:0]     in_b_q, in_b_d;
    logic signed [AW-1:0]        acc_q, acc_d;
    logic [NEURONS*WIDTH-1:0]    out_q, out_d;

    logic signed [WIDTH-1:0]     coeff_a [NEURONS];
    logic signed [WIDTH-1:0]     coeff_b [NEURONS];
    logic signed [WIDTH-1:0]     bias    [NEURONS];

    logic signed [WIDTH-1:0]     mul_x;
    logic signed [WIDTH-1:0]     mul_y;
    logic signed [PW-1:0]        product;
    logic signed [AW-1:0]        product_ext;
    logic signed [AW-1:0]        bias_shifted;
    logic                        acc_positive;

    // Coefficient banks only accept writes while idle, so a running
    // computation always sees a stable set of weights.
    for (genvar gi = 0; gi < NEURONS; gi++) begin : g_neuron
        logic signed [WIDTH-1:0] coeff_a_q;
        logic signed [WIDTH-1:0] coeff_b_q;
        logic signed [WIDTH-1:0] bias_q;
        logic                    wr_en;

        assign wr_en = cfg_we && (state_q == IDLE) && (cfg_addr[3:2] == 2'(gi));

        always_ff @(posedge clk) begin
            if (rst) begin
                coeff_a_q <= '0;
                coeff_b_q <= '0;
                bias_q    <= '0;
            end else if (wr_en) begin
                case (cfg_addr[1:0])
                    2'd0:    coeff_a_q <= cfg_data;
                    2'd1:    coeff_b_q <= cfg_data;
                    2'd2:    bias_q    <= cfg_data;
                    default: begin end
                endcase
            end
        end

        assign coeff_a[gi] = coeff_a_q;
        assign coeff_b[gi] = coeff_b_q;
        assign bias[gi]    = bias_q;
    end

    // One multiplier: operand pair chosen by which MAC step is running.
    always_comb begin
        mul_x = in_a_q;
        mul_y = coeff_a[idx_q];
        if (state_q == MAC_B) begin
            mul_x = in_b_q;
            mul_y = coeff_b[idx_q];
        end
    end

    assign product      = PW'(mul_x) * PW'(mul_y);
    assign product_ext  = AW'(product);
    assign bias_shifted = AW'(bias[idx_q]) <<< FRAC;
    assign acc_positive = !acc_q[AW-1] && (acc_q != '0);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        in_a_d  = in_a_q;
        in_b_d  = in_b_q;
        acc_d   = acc_q;
        out_d   = out_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    in_a_d  = inputA;
                    in_b_d  = inputB;
                    idx_d   = '0;
                    state_d = MAC_A;
                end
            end
            MAC_A: begin
                acc_d   = bias_shifted + product_ext;
                state_d = MAC_B;
            end
            MAC_B: begin
                acc_d   = acc_q + product_ext;
                state_d = ACT;
            end
            ACT: begin
                out_d[idx_q*WIDTH +: WIDTH] = acc_positive ? ONE_Q : '0;
                if (idx_q == LAST_IDX) begin
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDXW'(1);
                    state_d = MAC_A;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            in_a_q  <= '0;
            in_b_q  <= '0;
            acc_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            in_a_q  <= in_a_d;
            in_b_q  <= in_b_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_q;

endmodule

// File: doc/neural_layer_scheduler.md
NEURAL_LAYER_SCHEDULER -- requirements
Module: neural_layer_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the signed fixed-point word width, Q(WIDTH/2).(WIDTH/2).
REQ-002 SHALL have parameter NEURONS, default 2, legal range 1..4, meaning the number of neurons evaluated per input pair.
REQ-003 SHALL have port clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  meaning the reset; it is synchronous and active-high.
REQ-005 SHALL have port cfg_we  input  1  meaning the coefficient write strobe.
REQ-006 SHALL have port cfg_addr  input  4  meaning the coefficient address, {neuron[1:0], sel[1:0]}, with sel 0=coeffA, 1=coeffB, 2=bias, 3=reserved.
REQ-007 SHALL have port cfg_data  input  WIDTH  meaning the coefficient write data.
REQ-008 SHALL have port in_valid  input  1  meaning that inputA/inputB carry a valid pair.
REQ-009 SHALL have port in_ready  output  1  meaning the scheduler accepts a pair this cycle.
REQ-010 SHALL have port inputA  input  WIDTH  meaning the first layer input.
REQ-011 SHALL have port inputB  input  WIDTH  meaning the second layer input.
REQ-012 SHALL have port out_valid  output  1  meaning that out_data holds a complete result vector.
REQ-013 SHALL have port out_ready  input  1  meaning the consumer takes the result.
REQ-014 SHALL have port out_data  output  NEURONS*WIDTH  meaning the neuron i result at bits [i*WIDTH +: WIDTH].
REQ-015 SHALL have port busy  output  1  meaning the state is not IDLE.

Function
REQ-016 SHALL hold per neuron three WIDTH-bit coefficient registers (coeffA, coeffB, bias), written when cfg_we=1, state=IDLE, neuron<NEURONS and sel<3; all other writes are ignored.
REQ-017 SHALL implement states IDLE, MAC_A, MAC_B, ACT and DONE, with a neuron index idx of 0..NEURONS-1.
REQ-018 SHALL drive in_ready=1 only in IDLE; on in_valid&in_ready it SHALL capture inputA/inputB, set idx=0 and go to MAC_A.
REQ-019 SHALL, in MAC_A, load acc = (bias[idx] <<< WIDTH/2) + inputA*coeffA[idx] and go to MAC_B.
REQ-020 SHALL, in MAC_B, add inputB*coeffB[idx] to acc and go to ACT.
REQ-021 SHALL, in ACT, write slice idx of out_data with 1<<(WIDTH/2) (1.0) if acc>0, else 0; it SHALL then go to MAC_A with idx+1, or to DONE if idx=NEURONS-1.
REQ-022 SHALL form all products as signed WIDTH x WIDTH to 2*WIDTH bits and keep acc signed at 2*WIDTH+2 bits, so no overflow or saturation is possible; acc=0 SHALL yield 0.
REQ-023 SHALL make a single multiplier the only product resource, with one product per cycle.
REQ-024 SHALL assert out_valid exactly in DONE, 3*NEURONS cycles after the accept edge (6 at default).
REQ-025 SHALL, in DONE, hold out_data stable until out_valid&out_ready, then return to IDLE; a new pair SHALL be accepted no earlier than the cycle after.
REQ-026 SHALL not change out_data outside ACT.
REQ-027 SHALL apply a write and an accept in the same IDLE cycle together: the write lands, and the computation uses the new value.
REQ-028 SHALL ignore cfg writes while busy=1, with no effect on the coefficients.

Reset
REQ-029 SHALL, when rst=1 at an edge (including mid-computation), go to IDLE, set idx=0, clear acc, clear out_data to 0, clear all coefficients to 0, set out_valid=0 and set busy=0, with in_ready=1 on the following cycle.
REQ-030 SHALL give rst priority over cfg_we and in_valid in the same cycle.

Verification
REQ-031 SHALL cover basic sequencing: n0 = {A=0x0100, B=0x0100, bias=0xFF00}, n1 = {A=0x0100, B=0x0000, bias=0xFF00}, input (0x0100, 0x0080) -> out_valid 6 cycles after accept, out_data = {n1=0x0000 (acc=0 boundary), n0=0x0100}.
REQ-032 SHALL cover extremes: all coefficients 0x7FFF, inputs 0x7FFF -> 0x0100 per neuron; inputA=0x8000, coeffA=0x7FFF, others 0 -> 0x0000.
REQ-033 SHALL cover backpressure: out_ready low for 5 cycles in DONE -> out_valid, out_data stable, in_ready=0; the release cycle returns to IDLE.
REQ-034 SHALL cover a write while busy: write coeffA of n0 = 0x0200 during MAC_B -> the result is unchanged and a readback compute uses the old value.
REQ-035 SHALL cover reset mid-computation: rst pulse in ACT of n0 -> next cycle IDLE, out_data=0, out_valid=0, and a compute afterward with zeroed coefficients gives 0x0000 for all neurons.
REQ-036 SHALL cover a same-cycle write and accept: write bias of n0 = 0x0100 with inputs 0 -> out_data n0 = 0x0100.
